rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Eight-way round-robin arbiter that shares one downstream resource among eight requesters. It issues a registered one-hot grant and its 3-bit binary index, so the index can drive the shared datapath's select lines directly. The grant is held while the owner keeps requesting, and ownership rotates fairly afterwards. It sits between the requester bank and the shared resource's mux select.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive grant cycles per owner when the hold limit is compiled in. Legal range is 2..255.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset. Assertion takes effect immediately; release is expected synchronous to `clk`.
- `req` input 8: request vector; bit i is requester i, level-sensitive.
- `gnt` output 8: registered one-hot grant; all zero when no owner.
- `gnt_idx` output 3: binary index of the set `gnt` bit; 3'd0 when `gnt_valid` is low.
- `gnt_valid` output 1: high iff `gnt` is non-zero.

## Operation
- Two states:
  - IDLE: no owner.
  - BUSY: owner held in a 3-bit register.
- Priority pointer `ptr` (3 bits) names the highest-priority requester. The search order is ptr, ptr+1, …, ptr+7 mod 8, so index 7 wraps to 0.
- IDLE → BUSY when `req` ≠ 0. The winner is the first set bit in pointer order. On grant, ptr ← winner+1 mod 8.
- BUSY, `req[owner]`=1 (and no hold-limit expiry): stay in BUSY with the same owner. Other requests are ignored.
- BUSY, `req[owner]`=0 and another request present: hand over directly to the next winner in pointer order with no idle bubble, and update ptr.
- BUSY, `req[owner]`=0 and no other request: go to IDLE. `gnt` is 0 in the next cycle.
- Simultaneous requests are resolved only by pointer order. No requester can win twice in a row while another is waiting at the release point.
- Outputs are pure functions of the registers: `gnt` = decoded owner gated by BUSY, `gnt_idx` = owner, `gnt_valid` = BUSY.
- Reset values: state IDLE, ptr 3'd0, owner 3'd0, hold count 0, `gnt` 8'h00, `gnt_idx` 3'd0, `gnt_valid` 0.
- Reset mid-grant drops `gnt` asynchronously in the same instant. After release, arbitration restarts from ptr 0.

## Timing
- Request to grant latency is 1 cycle. A `req` bit sampled at edge n appears as `gnt` after edge n.
- Release to handover is 1 cycle. `req[owner]` sampled low at edge n means the new owner, or no owner, is visible after edge n.
- The grant never glitches between edges, and at most one `gnt` bit is ever set.
- A requester must hold `req` high until granted. Dropping it earlier simply withdraws the request, with no side effect.

## Configuration
- Macro `ARB_HOLD_LIMIT_EN`.
- Defined:
  - An 8-bit hold counter clears on every new grant and increments each BUSY cycle with an unchanged owner.
  - When the counter reaches `MAX_HOLD`-1 and any other `req` bit is set, the owner is forcibly handed over at the next edge to the next winner in pointer order, even if `req[owner]` is still high.
  - If no other request is pending, the owner keeps the grant and the counter saturates at `MAX_HOLD`-1.
- Undefined: there is no counter and ownership is held indefinitely while `req[owner]`=1.

## Structure
- Package `arb_pkg`:
  - `ARB_N`=8 and `ARB_IDX_W`=3.
  - The state enum {ARB_IDLE, ARB_BUSY}.
  - The default `MAX_HOLD`.
- Sub-module `onehot_enc8`: combinational 8-to-3 one-hot-to-index encoder. It outputs 3'd0 for a zero or non-one-hot input. It is used to encode the rotated first-set-bit winner into an index.
- Everything else (pointer rotation, FSM, counter) lives in `rr_arbiter8`.

## Test plan
- Reset: hold `rst_n`=0 with `req`=8'hFF → `gnt`=8'h00, `gnt_idx`=0, `gnt_valid`=0. Assert `rst_n` mid-grant → outputs clear without waiting for a clock edge.
- Single requester: `req`=8'h08 → one cycle later `gnt`=8'h08, `gnt_idx`=3. Drop `req` → `gnt`=8'h00 the next cycle.
- Rotation: `req`=8'hFF held, each owner drops its bit for one cycle after a grant → grant order is 0,1,2,…,7,0 with no idle cycles between owners.
- Wrap and ptr: grant to 7, then `req`=8'h81 → the next grant goes to 0 (8'h01), not 7.
- Direct handover: owner 2 with `req`=8'h24; drop bit 2 → `gnt`=8'h20 after one edge with `gnt_valid` continuously high.
- Hold limit (`ARB_HOLD_LIMIT_EN`, `MAX_HOLD`=4): `req`=8'h03 held constantly → `gnt` alternates 8'h01 for 4 cycles, then 8'h02 for 4 cycles. With `req`=8'h01 only → 8'h01 is held indefinitely. With the macro undefined → 8'h01 is held forever.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants and types for the eight-way round-robin arbiter.
// The optional hold limit is enabled by defining ARB_HOLD_LIMIT_EN.
package arb_pkg;

  localparam int ARB_N        = 8;
  localparam int ARB_IDX_W    = 3;
  localparam int ARB_MAX_HOLD = 16;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/onehot_enc8.sv
// Combinational 8-to-3 one-hot-to-index encoder.
// Returns 3'd0 when the input is zero or has more than one bit set.
module onehot_enc8
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]     onehot,
  output logic [ARB_IDX_W-1:0] idx
);

  logic [ARB_IDX_W-1:0] idx_or;
  logic                 is_onehot;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    idx_or = '0;
    for (int i = 0; i < ARB_N; i++) begin
      if (onehot[i]) idx_or = idx_or | ARB_IDX_W'(i);
    end
  end

  assign is_onehot = (onehot != '0) && ((onehot & (onehot - 1'b1)) == '0);
  assign idx       = is_onehot ? idx_or : '0;

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant and binary index.
// Define ARB_HOLD_LIMIT_EN to force a handover after MAX_HOLD cycles when others wait.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ARB_N-1:0]     req,
  output logic [ARB_N-1:0]     gnt,
  output logic [ARB_IDX_W-1:0] gnt_idx,
  output logic                 gnt_valid
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter8: MAX_HOLD must be in 2..255");
  end

  arb_state_e           state;
  logic [ARB_IDX_W-1:0] owner;
  logic [ARB_IDX_W-1:0] ptr;

  logic [ARB_N-1:0]     cand;
  logic [ARB_N-1:0]     rot;
  logic [ARB_N-1:0]     first;
  logic [ARB_IDX_W-1:0] offset;
  logic [ARB_IDX_W-1:0] win;
  logic                 busy;
  logic                 owner_drop;
  logic                 expire;
  logic                 new_grant;

  assign busy = (state == ARB_BUSY);

  // While busy the owner is never a candidate, so a forced handover cannot re-pick it.
  assign cand       = busy ? (req & ~(ARB_N'(1) << owner)) : req;
  assign rot        = ARB_N'({cand, cand} >> ptr);
  assign first      = rot & (~rot + 1'b1);
  assign win        = ptr + offset;
  assign owner_drop = busy && !req[owner];

  onehot_enc8 u_enc (
    .onehot (first),
    .idx    (offset)
  );

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt;

  assign expire = busy && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (new_grant) begin
      hold_cnt <= '0;
    end else if (busy && hold_cnt != HOLD_LAST) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  assign new_grant = (!busy || owner_drop || expire) && (cand != '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      owner <= '0;
      ptr   <= '0;
    end else if (new_grant) begin
      state <= ARB_BUSY;
      owner <= win;
      ptr   <= win + 1'b1;
    end else if (owner_drop) begin
      state <= ARB_IDLE;
    end
  end

  assign gnt       = busy ? (ARB_N'(1) << owner) : '0;
  assign gnt_idx   = busy ? owner : '0;
  assign gnt_valid = busy;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed steps plus random requests
// compared against a behavioural round-robin model.
module tb_rr_arbiter8;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int  TB_MAX_HOLD = 4;
  localparam bit  HOLD_EN     = 1'b1;
`else
  localparam int  TB_MAX_HOLD = 16;
  localparam bit  HOLD_EN     = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_hold;

  always #5 clk = ~clk;

  rr_arbiter8 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_hold  = 0;
  endtask

  // One rising edge of the arbiter as described by its rules.
  task automatic model_edge(input logic [7:0] r);
    logic [7:0] others;
    bit         move;
    others = r;
    if (m_busy) others[m_owner] = 1'b0;
    if (!m_busy)
      move = (r != 8'h00);
    else
      move = !r[m_owner] || (HOLD_EN && m_hold == TB_MAX_HOLD - 1 && others != 8'h00);
    if (move) begin
      if (others == 8'h00) begin
        m_busy = 1'b0;
      end else begin
        for (int k = 0; k < 8; k++) begin
          if (others[(m_ptr + k) % 8]) begin
            m_owner = (m_ptr + k) % 8;
            break;
          end
        end
        m_ptr  = (m_owner + 1) % 8;
        m_busy = 1'b1;
        m_hold = 0;
      end
    end else if (m_busy) begin
      if (m_hold < TB_MAX_HOLD - 1) m_hold++;
    end
  endtask

  task automatic compare_all(input string tag);
    logic [7:0] exp_gnt;
    exp_gnt = m_busy ? (8'h01 << m_owner) : 8'h00;
    check({tag, ".gnt"},       32'(gnt),       32'(exp_gnt));
    check({tag, ".gnt_idx"},   32'(gnt_idx),   m_busy ? 32'(m_owner) : 32'd0);
    check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(m_busy));
    check({tag, ".onehot"},    32'($countones(gnt) <= 1), 32'd1);
  endtask

  // Apply r for one edge, update the model, then sample 1 time unit after the edge.
  task automatic step(input logic [7:0] r, input string tag);
    req = r;
    model_edge(r);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst_n = 1'b1;
    req   = 8'h00;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    model_reset();
    #1;

    do_reset();

    // Single requester grant and release
    step(8'h08, "single");
    check("single.idx3", 32'(gnt_idx), 32'd3);
    step(8'h00, "single_drop");
    check("single_drop.gnt", 32'(gnt), 32'h00);

    // Rotation: each owner drops its bit right after being granted
    do_reset();
    step(8'hFF, "rot0");
    check("rot0.gnt", 32'(gnt), 32'h01);
    for (int k = 1; k <= 8; k++) begin
      step(8'hFF & ~(8'h01 << gnt_idx), "rot");
      check("rot.order", 32'(gnt), 32'(8'h01 << (k % 8)));
      check("rot.nobubble", 32'(gnt_valid), 32'd1);
    end

    // Wrap: grant 7, release, then 7 and 0 together -> 0 wins
    do_reset();
    step(8'h80, "wrap7");
    step(8'h00, "wrap_idle");
    step(8'h81, "wrap");
    check("wrap.gnt0", 32'(gnt), 32'h01);

    // Direct handover 2 -> 5 without an idle cycle
    do_reset();
    step(8'h04, "ho_own2");
    step(8'h24, "ho_hold");
    check("ho_hold.gnt", 32'(gnt), 32'h04);
    step(8'h20, "ho_drop");
    check("ho_drop.gnt", 32'(gnt), 32'h20);
    check("ho_drop.valid", 32'(gnt_valid), 32'd1);

    // Hold limit: two requesters held constantly
    do_reset();
    for (int c = 0; c < 20; c++) begin
      step(8'h03, "hold2");
      check("hold2.pattern", 32'(gnt),
            HOLD_EN ? (((c / TB_MAX_HOLD) % 2) != 0 ? 32'h02 : 32'h01) : 32'h01);
    end
    do_reset();
    for (int c = 0; c < 12; c++) begin
      step(8'h01, "hold1");
      check("hold1.kept", 32'(gnt), 32'h01);
    end

    // Random requests: mostly sticky owners, occasional drops and new arrivals
    do_reset();
    for (int c = 0; c < 300; c++) begin
      logic [7:0] r;
      r = 8'($urandom);
      if (m_busy && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
      if ($urandom_range(0, 9) == 0) r = 8'h00;
      step(r, "rand");
    end

    // Asynchronous reset in the middle of a grant
    step(8'h10, "async_pre");
    check("async_pre.gnt", 32'(gnt), 32'h10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async.gnt",   32'(gnt),       32'h00);
    check("async.idx",   32'(gnt_idx),   32'd0);
    check("async.valid", 32'(gnt_valid), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(8'hFF, "post_reset");
    check("post_reset.gnt0", 32'(gnt), 32'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
